// File: rtl/extest_pkg.sv
// Shared types and constants for the EXTEST scan sequencer and its helpers.
package extest_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        UPDATE,
        CAPTURE,
        UNLOAD,
        DONE
    } extest_state_t;

    localparam int unsigned EXTEST_N    = 8;
    localparam logic        EXTEST_FILL = 1'b0;

endpackage

// File: rtl/extest_shreg.sv
// N-bit shift register with parallel load and serial in/out, MSB shifted out first.
module extest_shreg #(
    parameter int unsigned N = 8
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         load_i,
    input  logic [N-1:0] par_i,
    input  logic         shift_i,
    input  logic         ser_i,
    output logic         ser_o,
    output logic [N-1:0] nxt_o
);

    logic [N-1:0] sr_q, sr_d;

    // Load has priority over shift.
    always_comb begin
        sr_d = sr_q;
        if (load_i) begin
            sr_d = par_i;
        end else if (shift_i) begin
            sr_d = {sr_q[N-2:0], ser_i};
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign ser_o = sr_q[N-1];
    assign nxt_o = sr_d;

endmodule

// File: rtl/extest_scan_ctrl.sv
// EXTEST session sequencer: shifts a stimulus pattern into the wrapper chain,
// strobes update/capture, and unloads the captured response into a parallel word.
module extest_scan_ctrl
    import extest_pkg::*;
#(
    parameter int unsigned N = EXTEST_N
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         start_i,
    input  logic [N-1:0] pattern_in_i,
    output logic         busy_o,
    output logic         done_o,
    output logic [N-1:0] response_out_o,
    output logic         extest_mode_o,
    output logic         wr_shift_o,
    output logic         wr_update_o,
    output logic         wr_capture_o,
    output logic         extest_scan_in_o,
    input  logic         extest_scan_out_i
);

    localparam int unsigned CW = $clog2(N);
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    extest_state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  resp_out_q, resp_out_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          mode_q, mode_d;
    logic          shift_q, shift_d;
    logic          update_q, update_d;
    logic          capture_q, capture_d;

    logic          accept;
    logic [N-1:0]  resp_nxt;
    logic [N-1:0]  stim_nxt_unused;
    logic          resp_ser_unused;

    assign accept = (state_q == IDLE) && start_i;

    // Stimulus serialiser: the MSB flop drives the chain directly; fill bits trail the pattern.
    extest_shreg #(.N(N)) u_stim (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .load_i  (accept),
        .par_i   (pattern_in_i),
        .shift_i (state_q == SHIFT),
        .ser_i   (EXTEST_FILL),
        .ser_o   (extest_scan_in_o),
        .nxt_o   (stim_nxt_unused)
    );

    extest_shreg #(.N(N)) u_resp (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .load_i  (1'b0),
        .par_i   ('0),
        .shift_i (state_q == UNLOAD),
        .ser_i   (extest_scan_out_i),
        .ser_o   (resp_ser_unused),
        .nxt_o   (resp_nxt)
    );

    // Next state plus output decode from the next state, so every output is a flop.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        resp_out_d = resp_out_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                end
            end
            SHIFT: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = UPDATE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            UPDATE:  state_d = CAPTURE;
            CAPTURE: state_d = UNLOAD;
            UNLOAD: begin
                if (cnt_q == CNT_LAST) begin
                    state_d    = DONE;
                    cnt_d      = '0;
                    resp_out_d = resp_nxt;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d    = (state_d != IDLE);
        mode_d    = (state_d != IDLE);
        shift_d   = (state_d == SHIFT) || (state_d == UNLOAD);
        update_d  = (state_d == UPDATE);
        capture_d = (state_d == CAPTURE);
        done_d    = (state_d == DONE);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            resp_out_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            mode_q     <= 1'b0;
            shift_q    <= 1'b0;
            update_q   <= 1'b0;
            capture_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            resp_out_q <= resp_out_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            mode_q     <= mode_d;
            shift_q    <= shift_d;
            update_q   <= update_d;
            capture_q  <= capture_d;
        end
    end

    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign response_out_o = resp_out_q;
    assign extest_mode_o  = mode_q;
    assign wr_shift_o     = shift_q;
    assign wr_update_o    = update_q;
    assign wr_capture_o   = capture_q;

endmodule

// File: doc/extest_scan_ctrl.md
# extest_scan_ctrl

Sequencer that drives the serial EXTEST chain of the extest wrapper (N wrapper boundary cells: 4 input WBCs and 4 output WBCs by default). It accepts a parallel N-bit stimulus pattern through a start/done handshake. It then generates the wrapper shift/update/capture control sequence, serialises the pattern onto `extest_scan_in`, and deserialises the unloaded response from `extest_scan_out` into a parallel word. It sits directly upstream of the wrapper, between the test-access controller and the boundary chain.

## Interface
- `N`, default 8: wrapper chain length in cells (≥2).
- `clk`  in  1  single clock; all state changes on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request one EXTEST session; sampled only in IDLE.
- `pattern_in`  in  N  stimulus; captured on the accepting edge.
- `busy`  out  1  high from the cycle after acceptance through the DONE cycle.
- `done`  out  1  one-cycle pulse; `response_out` is valid from this cycle onward.
- `response_out`  out  N  captured chain contents; held until the next session's DONE.
- `extest_mode`  out  1  high for the whole session (SHIFT..DONE), else low.
- `wr_shift`  out  1  wrapper shift enable.
- `wr_update`  out  1  wrapper update strobe.
- `wr_capture`  out  1  wrapper capture strobe.
- `extest_scan_in`  out  1  serial data to the first chain cell.
- `extest_scan_out`  in  1  serial data from the last chain cell (cell N-1).

## Operation
- FSM states: IDLE, SHIFT, UPDATE, CAPTURE, UNLOAD, DONE.
- IDLE: on `start`=1, latch `pattern_in` into the shift register, clear the bit counter, go to SHIFT. Otherwise stay in IDLE.
- SHIFT: lasts N cycles, with `wr_shift`=1.
  - `extest_scan_in` = pattern bit N-1-k in cycle k, so the MSB goes first.
  - After N shifts, cell k holds `pattern_in[k]`.
  - Then go to UPDATE.
- UPDATE: 1 cycle, `wr_update`=1. Then go to CAPTURE.
- CAPTURE: 1 cycle, `wr_capture`=1. Then go to UNLOAD.
- UNLOAD: lasts N cycles, with `wr_shift`=1 and `extest_scan_in`=0 (fill value).
  - Each rising edge does `resp <= {resp[N-2:0], extest_scan_out}`.
  - After N cycles, `resp[k]` = captured cell k.
  - Then go to DONE.
- DONE: 1 cycle.
  - `done`=1; `response_out` updated from `resp` on entry.
  - Next state is IDLE.
  - `start` is not accepted in DONE; it is accepted the following cycle, in IDLE.
- `start` while not in IDLE is ignored; no queueing.
- At most one of `wr_shift`, `wr_update`, `wr_capture` is high in any cycle.
- Bit counter width is $clog2(N). The terminal count is N-1 in SHIFT and in UNLOAD. The counter resets to 0 on every state exit.

## Timing
- All outputs are registered (driven from state/datapath flops, no combinational paths from inputs).
- `start` is accepted at edge t0. From t0+1:
  - SHIFT occupies cycles 1..N.
  - UPDATE occupies cycle N+1.
  - CAPTURE occupies cycle N+2.
  - UNLOAD occupies cycles N+3..2N+2.
  - DONE is at cycle 2N+3 (cycle 19 for N=8).
- Minimum start-to-start spacing is 2N+4 cycles.
- Reset values: state IDLE; `busy`, `done`, `extest_mode`, `wr_*`, `extest_scan_in` = 0; `response_out` = 0; counters and shift registers = 0.
- Reset asserted mid-session takes effect at that edge:
  - Return to IDLE with all outputs at reset values.
  - No `done`; `response_out` is cleared.
  - The partial wrapper state is abandoned.
- Reset and `start` high at the same edge: reset wins, and the session is not accepted.

## Structure
- Shared package `extest_pkg`:
  - State enum `extest_state_t` (IDLE..DONE).
  - Default chain length constant `EXTEST_N = 8`.
  - Fill-bit constant `EXTEST_FILL = 1'b0`.
- One natural sub-module: `extest_shreg`, an N-bit parallel-load/serial-in/serial-out shift register. It is instantiated twice, once for stimulus serialisation and once for response deserialisation.
- The top level holds the FSM, the bit counter and the output registers.

## Test plan
- Reset held 2 cycles, then released with `start`=0: all outputs 0 and `busy`=0 for 30 cycles.
- `pattern_in`=8'hA5, `start` pulse: `extest_scan_in` = 1,0,1,0,0,1,0,1 over SHIFT cycles 1–8. `wr_update` is at cycle 9, `wr_capture` at cycle 10, and `done` at cycle 19.
- Behavioural chain model whose capture inverts the updated value, `pattern_in`=8'hA5: `response_out`=8'h5A at DONE, held until the next DONE.
- `start` pulsed at cycles 5 and 19 after acceptance: both are ignored. `start` held high: the next session is accepted in the IDLE cycle after DONE, and `busy` rises 2 cycles after DONE.
- `reset` asserted in SHIFT cycle 3: next cycle is IDLE, `extest_mode`=0, no `done`, `response_out`=0. A new `start` with `pattern_in`=8'h3C completes normally.
- N=4 parameter build with `pattern_in`=4'b1001: `done` at cycle 11, and shift and unload each last 4 cycles.
